tcp_tx_arbiter: RTL and testbench

TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

---
 rtl/tcp_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_arbiter.sv
// Packet-granular round-robin arbiter merging four byte streams into the SiTCP TX port.
// Optionally prefixes each packet with a tag byte; drains packets when the connection drops.
module tcp_tx_arbiter #(
  parameter int         HDR_EN  = 1,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TCP_OPEN_ACK,
  input  logic        TCP_TX_FULL,
  input  logic [3:0]  CH_VALID,
  input  logic [31:0] CH_DATA,
  input  logic [3:0]  CH_LAST,
  output logic [3:0]  CH_READY,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  output logic [3:0]  GRANT,
  output logic        PKT_DROP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        wr_q, wr_d;
  logic [7:0]  data_q, data_d;
  logic        drop_q, drop_d;

  logic [7:0]  ch_byte [4];
  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        ready_sel;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_byte;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign ch_byte[gi] = CH_DATA[8*gi +: 8];
  end

  assign sel_valid = CH_VALID[gidx_q];
  assign sel_last  = CH_LAST[gidx_q];
  assign sel_byte  = ch_byte[gidx_q];

  // Search starts one past the last channel that completed a packet.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && CH_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    drop_d    = 1'b0;
    ready_sel = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TCP_OPEN_ACK && win_found) begin
          gidx_d  = win_idx;
          state_d = (HDR_EN != 0) ? S_HEADER : S_DATA;
        end
      end
      S_HEADER: begin
        if (!TCP_OPEN_ACK) begin
          state_d = S_FLUSH;
        end else if (!TCP_TX_FULL) begin
          wr_d    = 1'b1;
          data_d  = {HDR_TAG, 2'b00, gidx_q};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        ready_sel = !TCP_TX_FULL && TCP_OPEN_ACK;
        if (ready_sel && sel_valid) begin
          wr_d   = 1'b1;
          data_d = sel_byte;
          if (sel_last) begin
            state_d = S_IDLE;
            ptr_d   = gidx_q;
          end
        end else if (!TCP_OPEN_ACK) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Bytes of an orphaned packet are swallowed until its LAST beat.
        ready_sel = 1'b1;
        if (sel_valid && sel_last) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
          ptr_d   = gidx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CH_READY         = 4'b0000;
    CH_READY[gidx_q] = ready_sel;
  end

  assign GRANT       = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << gidx_q);
  assign TCP_TX_WR   = wr_q;
  assign TCP_TX_DATA = data_q;
  assign PKT_DROP    = drop_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gidx_q  <= 2'd0;
      ptr_q   <= 2'd3;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: a vector table for one packet, then stream
// sequences for round-robin order, back-pressure, flush, reset and headerless mode.
module tb_tcp_tx_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, open_ack, tx_full;
  logic [3:0]  ch_valid, ch_last, ch_ready, grant;
  logic [31:0] ch_data;
  logic        tx_wr, pkt_drop;
  logic [7:0]  tx_data;

  logic        open2, full2, wr2, drop2;
  logic [3:0]  valid2, last2, ready2, grant2;
  logic [31:0] data2;
  logic [7:0]  txd2;

  tcp_tx_arbiter #(.HDR_EN(1), .HDR_TAG(4'hA)) dut (
    .CLK(clk), .RST(rst), .TCP_OPEN_ACK(open_ack), .TCP_TX_FULL(tx_full),
    .CH_VALID(ch_valid), .CH_DATA(ch_data), .CH_LAST(ch_last), .CH_READY(ch_ready),
    .TCP_TX_WR(tx_wr), .TCP_TX_DATA(tx_data), .GRANT(grant), .PKT_DROP(pkt_drop)
  );

  tcp_tx_arbiter #(.HDR_EN(0), .HDR_TAG(4'hA)) dut_nohdr (
    .CLK(clk), .RST(rst), .TCP_OPEN_ACK(open2), .TCP_TX_FULL(full2),
    .CH_VALID(valid2), .CH_DATA(data2), .CH_LAST(last2), .CH_READY(ready2),
    .TCP_TX_WR(wr2), .TCP_TX_DATA(txd2), .GRANT(grant2), .PKT_DROP(drop2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        open;
    logic        full;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [7:0]  e_data;
    logic [3:0]  e_grant;
    logic        e_drop;
  } vec_t;

  vec_t vt [7];

  // Channel sources: bit 8 of each entry marks the LAST byte.
  logic [8:0] pkt_mem [4][0:31];
  int         rd_ptr [4];
  int         wr_cnt [4];
  bit         full_at [0:63];
  bit         open_at [0:63];
  logic [7:0] cap [$];
  logic [7:0] expq [$];
  int         drop_cnt;

  task automatic clear_streams();
    for (int i = 0; i < 4; i++) begin
      rd_ptr[i] = 0;
      wr_cnt[i] = 0;
      for (int j = 0; j < 32; j++) pkt_mem[i][j] = 9'h000;
    end
    for (int c = 0; c < 64; c++) begin
      full_at[c] = 1'b0;
      open_at[c] = 1'b1;
    end
    cap.delete();
    expq.delete();
    drop_cnt = 0;
  endtask

  task automatic push_pkt(input int ch, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      pkt_mem[ch][wr_cnt[ch]] = {(j == n - 1), base + 8'(j)};
      wr_cnt[ch]++;
    end
  endtask

  task automatic run_streams(input int ncyc);
    bit         prev_full;
    logic [3:0] hs;
    prev_full = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ch_valid[i]       = (rd_ptr[i] < wr_cnt[i]);
        ch_data[8*i +: 8] = pkt_mem[i][rd_ptr[i]][7:0];
        ch_last[i]        = pkt_mem[i][rd_ptr[i]][8];
      end
      tx_full  = full_at[c];
      open_ack = open_at[c];
      #1;
      if (tx_wr) cap.push_back(tx_data);
      if (pkt_drop) drop_cnt++;
      if (tx_full) chk("ready_blocked_by_full", 32'(ch_ready), 32'h0);
      if (prev_full) chk("no_wr_after_full", 32'(tx_wr), 32'h0);
      prev_full = tx_full;
      hs = ch_valid & ch_ready;
      for (int i = 0; i < 4; i++) if (hs[i]) rd_ptr[i]++;
    end
  endtask

  task automatic check_cap(input string name);
    int n;
    chk({name, "_len"}, 32'(cap.size()), 32'(expq.size()));
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) chk(name, 32'(cap[i]), 32'(expq[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ch_valid = 4'b0; ch_last = 4'b0; ch_data = 32'h0;
    open_ack = 1'b1; tx_full = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_wr", 32'(tx_wr), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(ch_ready), 32'h0);
    chk("rst_drop", 32'(pkt_drop), 32'h0);
  endtask

  initial begin
    int wr_seen;
    logic [7:0] byte_seen;
    bit accepted;

    vt[0] = '{1'b1, 1'b0, 4'b0001, 32'h11, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'b0001, 32'h11, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b0};
    vt[2] = '{1'b1, 1'b0, 4'b0001, 32'h11, 4'b0000, 4'b0001, 1'b1, 8'hA0, 4'b0001, 1'b0};
    vt[3] = '{1'b1, 1'b0, 4'b0001, 32'h22, 4'b0000, 4'b0001, 1'b1, 8'h11, 4'b0001, 1'b0};
    vt[4] = '{1'b1, 1'b0, 4'b0001, 32'h33, 4'b0001, 4'b0001, 1'b1, 8'h22, 4'b0001, 1'b0};
    vt[5] = '{1'b1, 1'b0, 4'b0000, 32'h00, 4'b0001, 4'b0000, 1'b1, 8'h33, 4'b0000, 1'b0};
    vt[6] = '{1'b1, 1'b0, 4'b0000, 32'h00, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};

    rst = 1'b1; open_ack = 1'b1; tx_full = 1'b0;
    ch_valid = 4'b0; ch_last = 4'b0; ch_data = 32'h0;
    open2 = 1'b1; full2 = 1'b0; valid2 = 4'b0; last2 = 4'b0; data2 = 32'h0;
    clear_streams();
    do_reset();

    // Single 3-byte packet on ch0, cycle by cycle.
    foreach (vt[k]) begin
      @(negedge clk);
      rst = 1'b0;
      open_ack = vt[k].open; tx_full = vt[k].full;
      ch_valid = vt[k].valid; ch_data = vt[k].data; ch_last = vt[k].last;
      #1;
      $display("vec %0d: ready=%b wr=%b data=%h grant=%b drop=%b",
               k, ch_ready, tx_wr, tx_data, grant, pkt_drop);
      chk($sformatf("vec%0d_ready", k), 32'(ch_ready), 32'(vt[k].e_ready));
      chk($sformatf("vec%0d_wr", k), 32'(tx_wr), 32'(vt[k].e_wr));
      chk($sformatf("vec%0d_grant", k), 32'(grant), 32'(vt[k].e_grant));
      chk($sformatf("vec%0d_drop", k), 32'(pkt_drop), 32'(vt[k].e_drop));
      if (vt[k].e_wr) chk($sformatf("vec%0d_data", k), 32'(tx_data), 32'(vt[k].e_data));
    end

    // Round-robin with all channels busy.
    do_reset();
    clear_streams();
    push_pkt(0, 8'h00, 2); push_pkt(0, 8'h02, 2);
    push_pkt(1, 8'h10, 2); push_pkt(2, 8'h20, 2); push_pkt(3, 8'h30, 2);
    run_streams(30);
    expq = '{8'hA0, 8'h00, 8'h01, 8'hA1, 8'h10, 8'h11, 8'hA2, 8'h20, 8'h21,
             8'hA3, 8'h30, 8'h31, 8'hA0, 8'h02, 8'h03};
    check_cap("rr_order");
    $display("rr: %0d bytes written", cap.size());

    // Back-pressure for 5 cycles in the middle of a ch2 packet.
    clear_streams();
    push_pkt(2, 8'h40, 6);
    for (int c = 5; c < 10; c++) full_at[c] = 1'b1;
    run_streams(20);
    expq = '{8'hA2, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    check_cap("full_stall");
    $display("full stall: %0d bytes written", cap.size());

    // Connection lost after 2 of 6 bytes on ch1; ch2 waits behind it.
    clear_streams();
    push_pkt(1, 8'h50, 6);
    push_pkt(2, 8'h60, 1);
    for (int c = 4; c < 9; c++) open_at[c] = 1'b0;
    run_streams(16);
    expq = '{8'hA1, 8'h50, 8'h51, 8'hA2, 8'h60};
    check_cap("flush");
    chk("flush_drop_pulses", 32'(drop_cnt), 32'd1);
    chk("flush_drained", 32'(rd_ptr[1]), 32'd6);
    $display("flush: %0d bytes written, %0d drops", cap.size(), drop_cnt);

    // Reset in the middle of a ch3 packet; ch0 must win afterwards.
    clear_streams();
    push_pkt(3, 8'h70, 5);
    run_streams(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_wr", 32'(tx_wr), 32'h0);
    chk("midrst_data", 32'(tx_data), 32'h0);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_ready", 32'(ch_ready), 32'h0);
    chk("midrst_drop", 32'(pkt_drop), 32'h0);
    push_pkt(0, 8'h05, 1);
    cap.delete();
    run_streams(16);
    expq = '{8'hA0, 8'h05, 8'hA3, 8'h72, 8'h73, 8'h74};
    check_cap("after_rst");
    $display("after reset: first byte %h", (cap.size() > 0) ? cap[0] : 8'h00);

    // Headerless instance: single-byte packet on ch1.
    wr_seen = 0; byte_seen = 8'h00; accepted = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid2 = accepted ? 4'b0000 : 4'b0010;
      last2  = 4'b0010;
      data2  = 32'h0000_5A00;
      #1;
      if (wr2) begin
        wr_seen++;
        byte_seen = txd2;
      end
      if ((valid2 & ready2) != 4'b0000) accepted = 1'b1;
    end
    chk("nohdr_wr_count", 32'(wr_seen), 32'd1);
    chk("nohdr_byte", 32'(byte_seen), 32'h5A);
    $display("nohdr: %0d writes, byte %h", wr_seen, byte_seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
